io_irq_source: RTL and testbench

//  Interrupt-driven input peripheral: the device side of the core's int/ioin/ioread interface.

---
 rtl/io_irq_source_if.sv | 27 ++
 rtl/io_irq_source.sv | 72 +++++++
 tb/tb_io_irq_source.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/io_irq_source_if.sv
// Device-side interrupt/IO bundle between io_irq_source, its byte producer and the core.
// The slave modport is the peripheral; the master modport is the producer plus core side.
interface io_irq_source_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    src_data;
  logic          src_valid;
  logic          src_ready;
  logic          clr_ovf;
  logic          intr;
  logic [7:0]    ioin;
  logic          ioread;
  logic          overflow;
  logic [CW-1:0] count;

  modport slave (
    input  src_data, src_valid, clr_ovf, ioread,
    output src_ready, intr, ioin, overflow, count
  );

  modport master (
    output src_data, src_valid, clr_ovf, ioread,
    input  src_ready, intr, ioin, overflow, count
  );
endinterface

// File: rtl/io_irq_source.sv
// Interrupt-driven input peripheral: FIFO-buffers producer bytes and raises intr while data is pending.
// The head byte is shown on ioin and popped by the core's ioread strobe.
module io_irq_source #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IRQ_GAP = 2
) (
  input  logic            clock,
  input  logic            reset,
  io_irq_source_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned HW = (IRQ_GAP < 1) ? 1 : $clog2(IRQ_GAP + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [HW-1:0] hold_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  // Handshake decode uses registered state only, so ioread never reaches src_ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.src_valid && !full;
  assign drop  = bus.src_valid && full;
  assign pop   = bus.ioread && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;

      // Each pop restarts the holdoff so the ISR can return before intr reasserts.
      if (pop)                hold_q <= HW'(IRQ_GAP);
      else if (hold_q != '0)  hold_q <= hold_q - HW'(1);
    end
  end

  // Storage needs no reset: ioin is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.src_data;
  end

  assign bus.src_ready = !full;
  assign bus.ioin      = empty ? 8'h00 : mem[rd_ptr];
  assign bus.intr      = !empty && (hold_q == '0);
  assign bus.overflow  = ovf_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_io_irq_source.sv
// Directed bench for io_irq_source (DEPTH=4, IRQ_GAP=2) with hand-computed expectations.
module tb_io_irq_source;
  logic clock;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  io_irq_source_if #(.DEPTH(4)) bus ();

  io_irq_source #(.DEPTH(4), .IRQ_GAP(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one posedge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.src_valid = 1'b1;
    bus.src_data  = d;
    tick();
    bus.src_valid = 1'b0;
  endtask

  task automatic pop();
    bus.ioread = 1'b1;
    tick();
    bus.ioread = 1'b0;
  endtask

  initial begin
    bus.src_data  = 8'h00;
    bus.src_valid = 1'b0;
    bus.clr_ovf   = 1'b0;
    bus.ioread    = 1'b0;
    reset         = 1'b0;

    // Reset
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_int",   32'(bus.intr), 32'd0);
    check("rst_ioin",  32'(bus.ioin), 32'h00);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ready", 32'(bus.src_ready), 32'd1);
    check("rst_ovf",   32'(bus.overflow), 32'd0);

    // Single byte
    push(8'h05);
    check("single_int",   32'(bus.intr), 32'd1);
    check("single_ioin",  32'(bus.ioin), 32'h05);
    check("single_count", 32'(bus.count), 32'd1);
    pop();
    check("single_pop_count", 32'(bus.count), 32'd0);
    check("single_pop_int",   32'(bus.intr), 32'd0);
    check("single_pop_ioin",  32'(bus.ioin), 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_int_stays_low", 32'(bus.intr), 32'd0);
    end

    // Holdoff
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("hold_pre_int", 32'(bus.intr), 32'd1);
    pop();
    check("hold_c0_int",  32'(bus.intr), 32'd0);
    check("hold_c0_ioin", 32'(bus.ioin), 32'h02);
    check("hold_count",   32'(bus.count), 32'd2);
    tick();
    check("hold_c1_int",  32'(bus.intr), 32'd0);
    tick();
    check("hold_c2_int",  32'(bus.intr), 32'd1);
    check("hold_c2_ioin", 32'(bus.ioin), 32'h02);
    pop();
    check("hold_drain_ioin", 32'(bus.ioin), 32'h03);
    pop();
    check("hold_drain_count", 32'(bus.count), 32'd0);
    tick();
    tick();

    // Full / overflow
    for (int i = 1; i <= 5; i++) begin
      push(8'(i));
      if (i == 4) begin
        check("full_ready", 32'(bus.src_ready), 32'd0);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_ovf_pre", 32'(bus.overflow), 32'd0);
      end
    end
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", 32'(bus.ioin), 32'(i));
      pop();
    end
    check("ovf_drained", 32'(bus.count), 32'd0);
    check("ovf_sticky",  32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_clear", 32'(bus.overflow), 32'd0);

    // Simultaneous push+pop when full: pop only; drop with clr_ovf keeps overflow set
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h14;
    bus.ioread    = 1'b1;
    bus.clr_ovf   = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    bus.ioread    = 1'b0;
    bus.clr_ovf   = 1'b0;
    check("full_pp_count", 32'(bus.count), 32'd3);
    check("full_pp_ioin",  32'(bus.ioin), 32'h11);
    check("set_wins_ovf",  32'(bus.overflow), 32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_clear2", 32'(bus.overflow), 32'd0);
    pop();
    check("mid_count", 32'(bus.count), 32'd2);

    // Push+pop at count=2
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h20;
    bus.ioread    = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    bus.ioread    = 1'b0;
    check("pp2_count", 32'(bus.count), 32'd2);
    check("pp2_ioin",  32'(bus.ioin), 32'h13);
    pop();
    check("pp2_order", 32'(bus.ioin), 32'h20);
    pop();
    check("pp2_empty", 32'(bus.count), 32'd0);

    // ioread while empty
    pop();
    check("empty_rd_count", 32'(bus.count), 32'd0);
    check("empty_rd_ioin",  32'(bus.ioin), 32'h00);
    check("empty_rd_ready", 32'(bus.src_ready), 32'd1);
    check("empty_rd_int",   32'(bus.intr), 32'd0);

    // Asynchronous reset mid-operation discards queued bytes
    tick();
    tick();
    push(8'hA1);
    push(8'hA2);
    check("pre_rst_count", 32'(bus.count), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_ioin",  32'(bus.ioin), 32'h00);
    check("async_rst_int",   32'(bus.intr), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.src_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
